// File: rtl/bnn_pkg.sv
// Shared types and helpers for the bit-serial BNN layer controllers.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bnn_out_slot.sv
// Single-entry valid/ready holding register; a load in the same cycle as a take wins.
module bnn_out_slot #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Frame sequencer: accepts one N x B vector, steps N accumulate beats, captures M sign bits.
module bnn_seq_ctrl
  import bnn_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned B = 4,
  parameter int unsigned M = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*B-1:0]           in_data,
  output logic                     acc_clr,
  output logic                     acc_en,
  output logic [idx_width(N)-1:0]  acc_idx,
  output logic [B-1:0]             acc_x,
  output logic                     acc_last,
  input  logic [M-1:0]             acc_sign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [M-1:0]             out_data
);

  localparam int unsigned IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [N-1:0][B-1:0]    vec_q;
  logic                   slot_free;
  logic                   capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      vec_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q <= in_data;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // idx parks at N-1 so acc_idx never shows an out-of-range row
          if (idx == LAST) state <= CAPT;
          else             idx   <= idx + 1'b1;
        end
        CAPT: begin
          if (slot_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign acc_clr  = in_ready && in_valid;
  assign acc_en   = (state == RUN);
  assign acc_idx  = idx;
  assign acc_x    = vec_q[idx];
  assign acc_last = acc_en && (idx == LAST);
  assign capture  = (state == CAPT) && slot_free;

  bnn_out_slot #(.W(M)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (acc_sign),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .free      (slot_free)
  );

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Directed bench for bnn_seq_ctrl with an accumulator model and an output scoreboard.
module tb_bnn_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        acc_clr;
  logic        acc_en;
  logic [1:0]  acc_idx;
  logic [3:0]  acc_x;
  logic        acc_last;
  logic [3:0]  acc_sign;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // weight row k selects +x (bit=1) or -x (bit=0) for neuron j
  logic [3:0] wrow [4] = '{4'b0111, 4'b0101, 4'b0101, 4'b1101};
  int         acc_m [4] = '{0, 0, 0, 0};
  logic [3:0] exp_q [$];
  logic [15:0] mon_vec = '0;
  int          beat = 0;

  always #5 clk = ~clk;

  bnn_seq_ctrl #(.N(4), .B(4), .M(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_idx   (acc_idx),
    .acc_x     (acc_x),
    .acc_last  (acc_last),
    .acc_sign  (acc_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] expected_signs(input logic [15:0] vec);
    int          s [4];
    logic [3:0]  x;
    logic [3:0]  res;
    for (int j = 0; j < 4; j++) s[j] = 0;
    for (int k = 0; k < 4; k++) begin
      x = vec[k*4 +: 4];
      for (int j = 0; j < 4; j++)
        s[j] = wrow[k][j] ? s[j] + int'(x) : s[j] - int'(x);
    end
    for (int j = 0; j < 4; j++) res[j] = (s[j] < 0);
    return res;
  endfunction

  function automatic logic [3:0] elem(input logic [15:0] vec, input int k);
    return vec[k*4 +: 4];
  endfunction

  // Accumulator bank model driven by the DUT's control outputs
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (acc_clr)
        acc_m[j] <= 0;
      else if (acc_en)
        acc_m[j] <= wrow[acc_idx][j] ? acc_m[j] + int'(acc_x) : acc_m[j] - int'(acc_x);
    end
  end

  always_comb begin
    acc_sign = '0;
    for (int j = 0; j < 4; j++) acc_sign[j] = (acc_m[j] < 0);
  end

  // Scoreboard and beat monitor
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      beat = 0;
    end else begin
      chk("clr_en_exclusive", 32'(acc_clr && acc_en), 32'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(expected_signs(in_data));
        mon_vec = in_data;
        beat = 0;
      end else if (acc_en) begin
        chk("beat_idx", 32'(acc_idx), 32'(beat));
        chk("beat_x", 32'(acc_x), 32'(elem(mon_vec, beat)));
        chk("beat_last", 32'(acc_last), 32'(beat == 3));
        beat++;
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
          pops++;
        end
      end
    end
  end

  task automatic wait_out(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [15:0] vec_b;
    logic [15:0] vec_c;
    logic [15:0] vec_e;
    vec_b = 16'h9e5a;
    vec_c = 16'h7c18;
    vec_e = 16'hf0a3;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_acc_clr", 32'(acc_clr), 32'd0);
    chk("rst_acc_en", 32'(acc_en), 32'd0);
    chk("rst_acc_last", 32'(acc_last), 32'd0);
    chk("rst_acc_idx", 32'(acc_idx), 32'd0);
    chk("rst_acc_x", 32'(acc_x), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Single frame, output held back so frame A stays in the slot
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4321; out_ready = 1'b0;
    #1 chk("a_acc_clr", 32'(acc_clr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b0;
      #1;
      chk("a_acc_en", 32'(acc_en), 32'd1);
      chk("a_acc_idx", 32'(acc_idx), 32'(k));
      chk("a_acc_x", 32'(acc_x), 32'(k + 1));
      chk("a_acc_last", 32'(acc_last), 32'(k == 3));
      chk("a_run_clr", 32'(acc_clr), 32'd0);
      chk("a_run_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); #1;
    chk("a_capt_en", 32'(acc_en), 32'd0);
    chk("a_capt_ready", 32'(in_ready), 32'd0);
    chk("a_capt_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("a_out_valid", 32'(out_valid), 32'd1);
    chk("a_out_data", 32'(out_data), 32'b1010);
    chk("a_in_ready", 32'(in_ready), 32'd1);

    // Back-pressure: frame B stalls in CAPT while A is held
    @(negedge clk);
    in_valid = 1'b1; in_data = vec_b;
    #1 chk("b_acc_clr", 32'(acc_clr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      chk("b_stall_ready", 32'(in_ready), 32'd0);
      chk("b_stall_en", 32'(acc_en), 32'd0);
      chk("b_stall_valid", 32'(out_valid), 32'd1);
      chk("b_stall_data", 32'(out_data), 32'b1010);
    end
    // Drain A and capture B in the same cycle
    @(negedge clk); out_ready = 1'b1;
    #1 chk("b_capt_en", 32'(acc_en), 32'd0);
    @(negedge clk); #1;
    chk("b_out_valid", 32'(out_valid), 32'd1);
    chk("b_out_data", 32'(out_data), 32'(expected_signs(vec_b)));
    chk("b_in_ready", 32'(in_ready), 32'd1);
    chk("b_pops_a_once", 32'(pops), 32'd1);
    @(negedge clk); #1;
    chk("b_drained", 32'(out_valid), 32'd0);
    chk("b_pops", 32'(pops), 32'd2);

    // Input ignored while busy; frame C held in the slot afterwards
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = vec_c;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = k[0]; in_data = 16'($urandom);
      #1;
      chk("c_run_clr", 32'(acc_clr), 32'd0);
      chk("c_run_x", 32'(acc_x), 32'(elem(vec_c, k)));
    end
    @(negedge clk); in_valid = 1'b0;
    #1 chk("c_capt_clr", 32'(acc_clr), 32'd0);
    @(negedge clk); #1;
    chk("c_out_valid", 32'(out_valid), 32'd1);
    chk("c_out_data", 32'(out_data), 32'(expected_signs(vec_c)));

    // Reset in the middle of frame D
    @(negedge clk); in_valid = 1'b1; in_data = 16'h5555;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("d_idx_before_rst", 32'(acc_idx), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("d_rst_in_ready", 32'(in_ready), 32'd1);
    chk("d_rst_out_valid", 32'(out_valid), 32'd0);
    chk("d_rst_out_data", 32'(out_data), 32'd0);
    chk("d_rst_acc_en", 32'(acc_en), 32'd0);
    chk("d_rst_acc_idx", 32'(acc_idx), 32'd0);
    in_valid = 1'b1; in_data = 16'h1234;
    repeat (2) @(negedge clk);
    #1 chk("d_rst_no_accept", 32'(acc_en), 32'd0);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("d_post_rst_idle", 32'(acc_en), 32'd0);

    // Frame E after reset produces its own signs
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = vec_e;
    @(negedge clk); in_valid = 1'b0;
    wait_out(10);
    chk("e_out_data", 32'(out_data), 32'(expected_signs(vec_e)));
    @(negedge clk); #1;
    chk("final_pops", 32'(pops), 32'd3);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_seq_ctrl.md
# bnn_seq_ctrl

Frame-level sequencer for the bit-serial binarized-neural-network layer datapath (M add/sub accumulators fed one B-bit input slice per cycle). It accepts one N×B-bit input vector through a valid/ready handshake and clears the accumulator bank. It then steps the slice/weight index across N beats and samples the M sign bits into an output holding register with its own valid/ready handshake. It replaces free-running counter control with restartable, back-pressurable, one-frame-at-a-time scheduling.

## Interface
- N, 4, input elements per vector (≥1)
- B, 4, bits per input element
- M, 4, neurons (accumulators) in the layer
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input vector offered
- in_ready  out  1  controller can accept a vector
- in_data  in  N*B  input vector, element k at [k*B +: B]
- acc_clr  out  1  synchronous clear of all accumulators
- acc_en  out  1  accumulate acc_x this cycle
- acc_idx  out  IW  current element index; also selects the weight row; IW = max(1, clog2(N))
- acc_x  out  B  selected element of the latched vector
- acc_last  out  1  final beat of the frame
- acc_sign  in  M  accumulator sign bits; reflect every beat whose enable edge has already occurred
- out_valid  out  1  out_data holds a finished frame
- out_ready  in  1  consumer takes out_data
- out_data  out  M  layer outputs of the last completed frame

## Operation
- States: IDLE, RUN, CAPT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into vec_q, assert acc_clr combinationally in the same cycle, set idx=0, go to RUN.
- RUN:
  - acc_en=1; acc_idx=idx; acc_x=vec_q[idx*B +: B].
  - acc_last=(idx==N-1).
  - Increment idx each cycle. On the acc_last cycle, go to CAPT (idx does not wrap past N-1).
- CAPT:
  - If !out_valid or out_ready: out_data←acc_sign, out_valid←1, go to IDLE.
  - Otherwise stall in CAPT. acc_en=0 while stalled, and the accumulators hold their value.
- Output slot:
  - out_valid clears on out_valid&&out_ready.
  - A capture in the same cycle wins: out_valid stays 1 and out_data takes the new frame.
- in_ready=0 in RUN and CAPT. in_valid and in_data changes are ignored there.
- acc_clr, acc_en and acc_last are 0 outside the cases above and are mutually consistent. acc_clr never coincides with acc_en.
- N=1: RUN lasts exactly one cycle, with acc_last=1 and acc_idx=0.

## Timing
- Reset values: state IDLE, idx 0, vec_q 0, out_valid 0, out_data 0. Hence in_ready=1, acc_clr/acc_en/acc_last=0, acc_idx=0, acc_x=0.
- Reset mid-frame aborts the frame, leaves out_data zero, and accepts nothing until rst deasserts. Accumulators are cleared by the next acc_clr, not by this block.
- Frame timeline, handshake in cycle t:
  - acc_clr at t.
  - RUN beats at t+1..t+N with acc_idx 0..N-1; acc_last at t+N.
  - CAPT at t+N+1.
  - out_valid=1 and in_ready=1 from t+N+2.
- Unstalled throughput: one frame per N+2 cycles; input-to-output latency N+2.
- Back-pressure on out_ready extends CAPT one cycle per stalled cycle. No data is lost or duplicated.
- All outputs except in_ready/acc_clr come from registers or from a mux on registered state. acc_clr depends combinationally on in_valid.

## Structure
- Shared package bnn_pkg:
  - State enum typedef (IDLE/RUN/CAPT).
  - Index-width function max(1, clog2(N)).
  - Nothing layer-specific.
- Sub-module bnn_out_slot: a single-entry valid/ready holding register (load, take, capture-wins rule), width M. Reusable for later layers.
- Controller FSM, idx counter, vec_q and slice mux live in bnn_seq_ctrl.

## Test plan
All scenarios use N=4, B=4, M=4.
- Reset: assert rst mid-cycle → in_ready=1, out_valid=0, out_data=0, acc_en=0 immediately (asynchronous).
- Single frame:
  - Stimulus: in_data=16'h4321 accepted at cycle 0; acc_sign model returns 4'b1010 at cycle 5.
  - Response: acc_clr at 0; acc_idx 0,1,2,3 with acc_x 1,2,3,4 at cycles 1–4; acc_last only at 4; out_data=4'b1010 and out_valid=1 at 6; in_ready=1 at 6.
- Back-pressure:
  - Stimulus: out_ready=0; frame A completes; frame B accepted.
  - Response: B holds in CAPT with in_ready=0 and acc_en=0. One cycle after out_ready=1, out_data switches to B's signs, out_valid stays 1, and A was seen exactly once.
- Simultaneous drain and capture: out_valid=1, out_ready=1 in B's CAPT cycle → next cycle out_valid=1 with B's data.
- Input ignored while busy: toggle in_valid and change in_data during RUN → no extra acc_clr, acc_x still follows the latched vector.
- Reset mid-RUN: rst at acc_idx=2 → IDLE, out_valid=0. A new frame after release produces its own correct signs.
